// File: rtl/npc_predict_if.sv
// Fetch/EX bus of the next-PC predictor. The master drives stall and EX resolution.
// The slave returns the fetch PC, the prediction, the flush and the perf counters.
interface npc_predict_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             stall_i;
  logic             ex_valid_i;
  logic             ex_is_jump_i;
  logic [XLEN-1:0]  ex_pc_i;
  logic             ex_taken_i;
  logic [XLEN-1:0]  ex_target_i;
  logic             ex_pred_taken_i;
  logic [XLEN-1:0]  ex_pred_target_i;
  logic [XLEN-1:0]  pc_o;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_target_o;
  logic             flush_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output stall_i, ex_valid_i, ex_is_jump_i, ex_pc_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i,
    input  pc_o, pred_taken_o, pred_target_o, flush_o, branch_cnt_o, mispred_cnt_o
  );
  modport slave (
    input  stall_i, ex_valid_i, ex_is_jump_i, ex_pc_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i,
    output pc_o, pred_taken_o, pred_target_o, flush_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/npc_predict.sv
// PC register with a direct-mapped BTB and 2-bit saturating counters.
// EX resolution redirects the PC and flushes IF/ID on a misprediction.
module npc_predict #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_3000,
  parameter int              BTB_ENTRIES = 16,
  parameter int              CNT_W       = 32
) (
  input logic          clk,
  input logic          rst,
  npc_predict_if.slave bus
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam logic [XLEN-1:0]  FOUR = XLEN'(4);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [XLEN-1:0]        pc;
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]   f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, pred_taken, taken, mispred, flush;
  logic [XLEN-1:0]  pred_target, next_pc, redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  assign f_idx = pc[IDX+1:2];
  assign f_tag = pc[XLEN-1:IDX+2];
  assign e_idx = bus.ex_pc_i[IDX+1:2];
  assign e_tag = bus.ex_pc_i[XLEN-1:IDX+2];

  // Lookup reads the array before this edge's write, so same-index updates show next cycle.
  assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign e_hit       = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
  assign pred_taken  = f_hit && btb_ctr[f_idx][1];
  assign pred_target = f_hit ? btb_target[f_idx] : '0;
  assign next_pc     = pred_taken ? pred_target : pc + FOUR;

  assign taken       = bus.ex_taken_i | bus.ex_is_jump_i;
  assign mispred     = (taken != bus.ex_pred_taken_i) ||
                       (taken && (bus.ex_target_i != bus.ex_pred_target_i));
  assign flush       = bus.ex_valid_i && mispred;
  assign redirect_pc = taken ? bus.ex_target_i : bus.ex_pc_i + FOUR;

  assign bus.pc_o          = pc;
  assign bus.pred_taken_o  = pred_taken;
  assign bus.pred_target_o = pred_target;
  assign bus.flush_o       = flush;
  assign bus.branch_cnt_o  = branch_cnt;
  assign bus.mispred_cnt_o = mispred_cnt;

  // A redirect wins over a stall: the stalled instruction is on the wrong path anyway.
  always_ff @(posedge clk) begin
    if (rst)              pc <= RESET_PC;
    else if (flush)       pc <= redirect_pc;
    else if (!bus.stall_i) pc <= next_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= '0;
      end
    end else if (bus.ex_valid_i) begin
      if (taken) begin
        btb_target[e_idx] <= bus.ex_target_i;
        if (e_hit) begin
          btb_ctr[e_idx] <= bus.ex_is_jump_i ? 2'b11 : sat_inc(btb_ctr[e_idx]);
        end else begin
          btb_valid[e_idx] <= 1'b1;
          btb_tag[e_idx]   <= e_tag;
          btb_ctr[e_idx]   <= bus.ex_is_jump_i ? 2'b11 : 2'b10;
        end
      end else if (e_hit) begin
        btb_ctr[e_idx] <= sat_dec(btb_ctr[e_idx]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (bus.ex_valid_i) branch_cnt  <= branch_cnt + ONE;
      if (flush)          mispred_cnt <= mispred_cnt + ONE;
    end
  end
endmodule
